// File: rtl/multiport_ram_pkg.sv
// Shared definitions for the multi-port RAM and its write arbiter.
// Contents:
//   index_width() - address/pointer width for a given entry count (minimum 1)
//   wr_req_t      - one write request (addr, data, valid), sized for the widest
//                   configuration; narrower users zero-extend into it.
package multiport_ram_pkg;

    localparam int unsigned LP_MAX_INDEX_WIDTH = 16;
    localparam int unsigned LP_MAX_MEM_WIDTH   = 128;

    function automatic int unsigned index_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef struct packed {
        logic [LP_MAX_INDEX_WIDTH-1:0] addr;
        logic [LP_MAX_MEM_WIDTH-1:0]   data;
        logic                          valid;
    } wr_req_t;

endpackage

// File: rtl/mpram_wr_arbiter_if.sv
// Bus between the write requesters, the write arbiter and the RAM write ports.
// Signals:
//   req_valid_i / req_addr_i / req_data_i - per-requester write request
//   req_ready_o                           - per-requester grant
//   wra_* / wrb_*                         - registered RAM write ports A and B
// Modports: master = requester/RAM side, slave = arbiter.
interface mpram_wr_arbiter_if
    import multiport_ram_pkg::*;
#(
    parameter int unsigned P_NUM_REQ   = 4,
    parameter int unsigned P_MEM_DEPTH = 16,
    parameter int unsigned P_MEM_WIDTH = 32
);
    localparam int unsigned LP_INDEX_WIDTH = index_width(P_MEM_DEPTH);

    logic [P_NUM_REQ-1:0]                     req_valid_i;
    logic [P_NUM_REQ-1:0][LP_INDEX_WIDTH-1:0] req_addr_i;
    logic [P_NUM_REQ-1:0][P_MEM_WIDTH-1:0]    req_data_i;
    logic [P_NUM_REQ-1:0]                     req_ready_o;

    logic [LP_INDEX_WIDTH-1:0] wra_addr_o;
    logic [P_MEM_WIDTH-1:0]    wra_data_o;
    logic                      wra_valid_o;
    logic [LP_INDEX_WIDTH-1:0] wrb_addr_o;
    logic [P_MEM_WIDTH-1:0]    wrb_data_o;
    logic                      wrb_valid_o;

    modport master (
        output req_valid_i, req_addr_i, req_data_i,
        input  req_ready_o,
        input  wra_addr_o, wra_data_o, wra_valid_o,
        input  wrb_addr_o, wrb_data_o, wrb_valid_o
    );

    modport slave (
        input  req_valid_i, req_addr_i, req_data_i,
        output req_ready_o,
        output wra_addr_o, wra_data_o, wra_valid_o,
        output wrb_addr_o, wrb_data_o, wrb_valid_o
    );

endinterface

// File: rtl/rr_pick.sv
// Round-robin picker: returns the first request, searching upward from start
// and wrapping, that is not masked.
// Ports:
//   req   - request vector
//   start - index where the search begins (must be < P_NUM_REQ)
//   mask  - requests to skip
//   grant - one-hot pick (all zero when nothing eligible)
//   found - a pick was made
module rr_pick #(
    parameter int unsigned P_NUM_REQ   = 4,
    parameter int unsigned P_PTR_WIDTH = 2
) (
    input  logic [P_NUM_REQ-1:0]   req,
    input  logic [P_PTR_WIDTH-1:0] start,
    input  logic [P_NUM_REQ-1:0]   mask,
    output logic [P_NUM_REQ-1:0]   grant,
    output logic                   found
);

    logic [P_NUM_REQ-1:0]   eligible;
    logic [P_NUM_REQ-1:0]   rot;
    logic [P_NUM_REQ-1:0]   first;
    logic [2*P_NUM_REQ-1:0] rot_grant;

    assign eligible = req & ~mask;

    always_comb begin
        // Rotate so the start index sits at bit 0, pick the lowest set bit,
        // then rotate the pick back into place.
        rot   = P_NUM_REQ'({eligible, eligible} >> start);
        first = '0;
        found = 1'b0;
        for (int i = 0; i < P_NUM_REQ; i++) begin
            if (rot[i] && !found) begin
                first[i] = 1'b1;
                found    = 1'b1;
            end
        end
        rot_grant = {{P_NUM_REQ{1'b0}}, first} << start;
        grant     = rot_grant[P_NUM_REQ-1:0] | rot_grant[2*P_NUM_REQ-1:P_NUM_REQ];
    end

endmodule

// File: rtl/mpram_wr_arbiter.sv
// Write arbiter for a two-write-port RAM. Grants up to two requesters per
// cycle in round-robin order; the second grant never targets the address of
// the first. Granted writes appear on port A / port B one cycle later.
// Ports:
//   clk_i   - clock, all state on rising edge
//   rst_ni  - asynchronous active-low reset
//   stall_i - downstream hold; no grants while high
//   bus     - requester handshake and RAM write ports (slave side)
module mpram_wr_arbiter
    import multiport_ram_pkg::*;
#(
    parameter int unsigned P_NUM_REQ   = 4,
    parameter int unsigned P_MEM_DEPTH = 16,
    parameter int unsigned P_MEM_WIDTH = 32
) (
    input logic               clk_i,
    input logic               rst_ni,
    input logic               stall_i,
    mpram_wr_arbiter_if.slave bus
);

    localparam int unsigned LP_INDEX_WIDTH = index_width(P_MEM_DEPTH);
    localparam int unsigned LP_PTR_WIDTH   = index_width(P_NUM_REQ);

    logic [LP_PTR_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [P_NUM_REQ-1:0]      grant_a, grant_b, mask_b;
    logic                      found_a, found_b, hold, fire_a, fire_b;
    logic [LP_INDEX_WIDTH-1:0] addr_a, addr_b;
    logic [P_MEM_WIDTH-1:0]    data_a, data_b;
    logic [LP_PTR_WIDTH-1:0]   idx_a, idx_b, last_idx;
    wr_req_t                   port_a_q, port_a_d, port_b_q, port_b_d;

    rr_pick #(
        .P_NUM_REQ  (P_NUM_REQ),
        .P_PTR_WIDTH(LP_PTR_WIDTH)
    ) u_pick_a (
        .req  (bus.req_valid_i),
        .start(rr_ptr_q),
        .mask ('0),
        .grant(grant_a),
        .found(found_a)
    );

    rr_pick #(
        .P_NUM_REQ  (P_NUM_REQ),
        .P_PTR_WIDTH(LP_PTR_WIDTH)
    ) u_pick_b (
        .req  (bus.req_valid_i),
        .start(rr_ptr_q),
        .mask (mask_b),
        .grant(grant_b),
        .found(found_b)
    );

    // Grant A selection; mask for B is every valid requester sharing grant A's
    // address, which includes grant A itself.
    always_comb begin
        addr_a = '0;
        data_a = '0;
        idx_a  = '0;
        mask_b = '0;
        for (int i = 0; i < P_NUM_REQ; i++) begin
            if (grant_a[i]) begin
                addr_a = bus.req_addr_i[i];
                data_a = bus.req_data_i[i];
                idx_a  = LP_PTR_WIDTH'(i);
            end
        end
        for (int i = 0; i < P_NUM_REQ; i++) begin
            mask_b[i] = found_a && bus.req_valid_i[i] && (bus.req_addr_i[i] == addr_a);
        end
    end

    // Kept apart from the grant A block: B depends on mask_b.
    always_comb begin
        addr_b = '0;
        data_b = '0;
        idx_b  = '0;
        for (int i = 0; i < P_NUM_REQ; i++) begin
            if (grant_b[i]) begin
                addr_b = bus.req_addr_i[i];
                data_b = bus.req_data_i[i];
                idx_b  = LP_PTR_WIDTH'(i);
            end
        end
    end

    // Reset also blocks grants so nothing is accepted while rst_ni is low.
    assign hold            = stall_i | ~rst_ni;
    assign fire_a          = found_a & ~hold;
    assign fire_b          = found_b & ~hold;
    assign bus.req_ready_o = hold ? '0 : (grant_a | grant_b);

    always_comb begin
        // B is always later in search order than A, so it is the last grant.
        last_idx = found_b ? idx_b : idx_a;
        rr_ptr_d = rr_ptr_q;
        if (fire_a) begin
            rr_ptr_d = (32'(last_idx) == P_NUM_REQ - 1) ? '0 : last_idx + LP_PTR_WIDTH'(1);
        end
    end

    always_comb begin
        port_a_d       = port_a_q;
        port_a_d.valid = fire_a;
        if (fire_a) begin
            port_a_d.addr = LP_MAX_INDEX_WIDTH'(addr_a);
            port_a_d.data = LP_MAX_MEM_WIDTH'(data_a);
        end
        port_b_d       = port_b_q;
        port_b_d.valid = fire_b;
        if (fire_b) begin
            port_b_d.addr = LP_MAX_INDEX_WIDTH'(addr_b);
            port_b_d.data = LP_MAX_MEM_WIDTH'(data_b);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
            port_a_q <= '0;
            port_b_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            port_a_q <= port_a_d;
            port_b_q <= port_b_d;
        end
    end

    assign bus.wra_addr_o  = LP_INDEX_WIDTH'(port_a_q.addr);
    assign bus.wra_data_o  = P_MEM_WIDTH'(port_a_q.data);
    assign bus.wra_valid_o = port_a_q.valid;
    assign bus.wrb_addr_o  = LP_INDEX_WIDTH'(port_b_q.addr);
    assign bus.wrb_data_o  = P_MEM_WIDTH'(port_b_q.data);
    assign bus.wrb_valid_o = port_b_q.valid;

endmodule

// File: tb/tb_mpram_wr_arbiter.sv
// Bench for mpram_wr_arbiter: directed scenarios followed by random traffic.
// A reference model derives grants from the round-robin rules each cycle and
// queues the expected port writes; a monitor pops and compares them.
module tb_mpram_wr_arbiter;

    localparam int NR    = 4;
    localparam int DEPTH = 16;
    localparam int W     = 32;
    localparam int IW    = 4;
    localparam int LIMIT = 6 * NR;

    typedef struct {
        logic          va;
        logic [IW-1:0] aa;
        logic [W-1:0]  da;
        logic          vb;
        logic [IW-1:0] ab;
        logic [W-1:0]  db;
    } exp_t;

    logic clk;
    logic rst_n;
    logic stall;

    mpram_wr_arbiter_if #(.P_NUM_REQ(NR), .P_MEM_DEPTH(DEPTH), .P_MEM_WIDTH(W)) bus ();

    mpram_wr_arbiter #(
        .P_NUM_REQ  (NR),
        .P_MEM_DEPTH(DEPTH),
        .P_MEM_WIDTH(W)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .stall_i(stall),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    exp_t exp_q[$];
    logic mon_en = 1'b0;

    // Requester state driven onto the bus at each step.
    logic          r_valid[NR];
    logic [IW-1:0] r_addr[NR];
    logic [W-1:0]  r_data[NR];

    // Reference model state.
    int            m_ptr;
    logic [IW-1:0] m_la_a, m_lb_a;
    logic [W-1:0]  m_la_d, m_lb_d;
    logic [NR-1:0] m_gnt;
    int            wait_cnt[NR];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_la_a = '0;
        m_lb_a = '0;
        m_la_d = '0;
        m_lb_d = '0;
        m_gnt  = '0;
        for (int i = 0; i < NR; i++) wait_cnt[i] = 0;
    endtask

    // Walk requesters in order from the pointer: first valid gets A, next valid
    // with a different address gets B.
    task automatic model_eval();
        int            ga, gb, last;
        logic [NR-1:0] er;
        exp_t          e;
        ga = -1;
        gb = -1;
        er = '0;
        if (!stall && rst_n) begin
            for (int k = 0; k < NR; k++) begin
                int i;
                i = (m_ptr + k) % NR;
                if (r_valid[i]) begin
                    if (ga < 0) ga = i;
                    else if (gb < 0 && r_addr[i] != r_addr[ga]) gb = i;
                end
            end
        end
        if (ga >= 0) er[ga] = 1'b1;
        if (gb >= 0) er[gb] = 1'b1;
        check("ready", 64'(bus.req_ready_o), 64'(er));
        check("rr_ptr", 64'(dut.rr_ptr_q), 64'(m_ptr));
        if (ga >= 0) begin
            m_la_a = r_addr[ga];
            m_la_d = r_data[ga];
        end
        if (gb >= 0) begin
            m_lb_a = r_addr[gb];
            m_lb_d = r_data[gb];
        end
        e.va = (ga >= 0);
        e.aa = m_la_a;
        e.da = m_la_d;
        e.vb = (gb >= 0);
        e.ab = m_lb_a;
        e.db = m_lb_d;
        exp_q.push_back(e);
        if (ga >= 0) begin
            last  = (gb >= 0) ? gb : ga;
            m_ptr = (last + 1) % NR;
        end
        if (!stall && rst_n) begin
            for (int i = 0; i < NR; i++) begin
                if (er[i]) begin
                    check("wait_bound", 64'(wait_cnt[i] <= LIMIT), 64'(1));
                    wait_cnt[i] = 0;
                end else if (r_valid[i]) begin
                    wait_cnt[i]++;
                end
            end
        end
        m_gnt = er;
    endtask

    task automatic set_req(input int i, input logic v, input logic [IW-1:0] a,
                           input logic [W-1:0] d);
        r_valid[i] = v;
        r_addr[i]  = a;
        r_data[i]  = d;
    endtask

    task automatic step(input logic st, input logic chk, input logic [NR-1:0] exp_rdy,
                        input int exp_ptr);
        @(negedge clk);
        stall = st;
        for (int i = 0; i < NR; i++) begin
            bus.req_valid_i[i] = r_valid[i];
            bus.req_addr_i[i]  = r_addr[i];
            bus.req_data_i[i]  = r_data[i];
        end
        #1;
        model_eval();
        mon_en = 1'b1;
        if (chk) begin
            check("dir_ready", 64'(bus.req_ready_o), 64'(exp_rdy));
            check("dir_ptr", 64'(dut.rr_ptr_q), 64'(exp_ptr));
        end
    endtask

    // Reset pulse inside a cycle that already has a grant pending.
    task automatic reset_pulse();
        #1 rst_n = 1'b0;
        #1;
        check("rst_wra_valid", 64'(bus.wra_valid_o), 64'(0));
        check("rst_wrb_valid", 64'(bus.wrb_valid_o), 64'(0));
        check("rst_wra_addr", 64'(bus.wra_addr_o), 64'(0));
        check("rst_ready", 64'(bus.req_ready_o), 64'(0));
        check("rst_ptr", 64'(dut.rr_ptr_q), 64'(0));
        for (int i = 0; i < NR; i++) r_valid[i] = 1'b0;
        bus.req_valid_i = '0;
        exp_q.delete();
        model_reset();
        #1 rst_n = 1'b1;
        #1 model_eval();
    endtask

    // Monitor: compare registered write ports against the queued expectations.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL mon_queue: got empty queue, expected an entry at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("wra_valid", 64'(bus.wra_valid_o), 64'(e.va));
                    check("wra_addr", 64'(bus.wra_addr_o), 64'(e.aa));
                    check("wra_data", 64'(bus.wra_data_o), 64'(e.da));
                    check("wrb_valid", 64'(bus.wrb_valid_o), 64'(e.vb));
                    check("wrb_addr", 64'(bus.wrb_addr_o), 64'(e.ab));
                    check("wrb_data", 64'(bus.wrb_data_o), 64'(e.db));
                    if (bus.wra_valid_o && bus.wrb_valid_o)
                        check("ab_addr_distinct", 64'(bus.wra_addr_o != bus.wrb_addr_o), 64'(1));
                end
            end
        end
    end

    initial begin
        rst_n           = 1'b0;
        stall           = 1'b0;
        bus.req_valid_i = '1;
        bus.req_addr_i  = '0;
        bus.req_data_i  = '0;
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, '0, '0);
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_ready", 64'(bus.req_ready_o), 64'(0));
        check("reset_wra_valid", 64'(bus.wra_valid_o), 64'(0));
        check("reset_wrb_valid", 64'(bus.wrb_valid_o), 64'(0));
        check("reset_wra_data", 64'(bus.wra_data_o), 64'(0));
        check("reset_ptr", 64'(dut.rr_ptr_q), 64'(0));
        bus.req_valid_i = '0;
        rst_n           = 1'b1;

        // Single requester after reset.
        set_req(0, 1'b1, 4'd3, 32'hA5);
        step(1'b0, 1'b1, 4'b0001, 0);
        set_req(0, 1'b0, 4'd3, 32'hA5);
        step(1'b0, 1'b1, 4'b0000, 1);
        check("d1_wra_valid", 64'(bus.wra_valid_o), 64'(1));
        check("d1_wra_addr", 64'(bus.wra_addr_o), 64'(3));
        check("d1_wra_data", 64'(bus.wra_data_o), 64'hA5);
        check("d1_wrb_valid", 64'(bus.wrb_valid_o), 64'(0));

        // Move pointer back to 0 by granting requester 3 alone.
        set_req(3, 1'b1, 4'd7, 32'h103);
        step(1'b0, 1'b1, 4'b1000, 1);

        // All valid, distinct addresses.
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 4'(i + 1), 32'(32'h100 + i));
        step(1'b0, 1'b1, 4'b0011, 0);
        step(1'b0, 1'b1, 4'b1100, 2);

        // Address collision between requesters 0 and 1.
        set_req(0, 1'b1, 4'd5, 32'h200);
        set_req(1, 1'b1, 4'd5, 32'h201);
        set_req(2, 1'b1, 4'd6, 32'h202);
        set_req(3, 1'b0, 4'd0, 32'h0);
        step(1'b0, 1'b1, 4'b0101, 0);
        set_req(0, 1'b0, 4'd5, 32'h200);
        set_req(2, 1'b0, 4'd6, 32'h202);
        step(1'b0, 1'b1, 4'b0010, 3);

        // Stall with everyone valid, then release.
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 4'(i + 1), 32'(32'h300 + i));
        repeat (3) step(1'b1, 1'b1, 4'b0000, 2);
        step(1'b0, 1'b1, 4'b1100, 2);

        // Reset pulse with a write pending.
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, '0, '0);
        set_req(2, 1'b1, 4'd9, 32'h400);
        step(1'b0, 1'b1, 4'b0100, 0);
        reset_pulse();
        set_req(1, 1'b1, 4'd8, 32'h501);
        set_req(3, 1'b1, 4'd9, 32'h503);
        step(1'b0, 1'b1, 4'b1010, 0);
        set_req(1, 1'b0, 4'd8, 32'h501);
        set_req(3, 1'b0, 4'd9, 32'h503);

        // Random traffic; requesters hold their request until granted.
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (m_gnt[i] || !r_valid[i]) begin
                    if ($urandom_range(0, 3) != 0)
                        set_req(i, 1'b1, 4'($urandom_range(0, DEPTH - 1)), 32'($urandom));
                    else
                        r_valid[i] = 1'b0;
                end
            end
            step(($urandom_range(0, 7) == 0), 1'b0, '0, 0);
        end

        for (int i = 0; i < NR; i++) r_valid[i] = 1'b0;
        step(1'b0, 1'b0, '0, 0);
        @(posedge clk);
        #2;
        mon_en = 1'b0;
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
